mp_add_seq: RTL and testbench

- Multi-precision add/subtract sequencer around a single WIDTH-bit prefix adder.
- Accepts a command giving operand length in words and the operation, then consumes operand word pairs least-significant first.
- Chains the carry between beats through the shared adder and streams sum words out with a last flag and carry/borrow status.
- Sits between a register-file/operand streamer and the result writeback in the arithmetic unit.

---
 rtl/mp_add_seq.sv | 123 ++++++++++++
 tb/tb_mp_add_seq.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer.
// Streams operand word pairs through one adder, chaining the carry.
module mp_add_seq #(
   parameter int WIDTH     = 16,
   parameter int MAX_WORDS = 8,
   localparam int CW       = $clog2(MAX_WORDS + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CW-1:0]    cmd_words,
   input  logic             cmd_sub,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_last,
   output logic             res_carry,
   output logic             busy
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic             carry_q, carry_d;
   logic             sub_q, sub_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CW-1:0]    eff_words;
   logic             res_valid_d;
   logic [WIDTH-1:0] res_sum_d;
   logic             res_last_d;
   logic             res_carry_d;
   logic             cmd_hs;
   logic             op_hs;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   add_full;

   // clamp requested length into 1..MAX_WORDS
   always_comb begin
      eff_words = cmd_words;
      if (cmd_words == '0)
         eff_words = CW'(1);
      else if (cmd_words > CW'(MAX_WORDS))
         eff_words = CW'(MAX_WORDS);
   end

   // single shared adder; subtract is A + ~B + carry
   always_comb begin
      b_eff    = sub_q ? ~op_b : op_b;
      add_full = {1'b0, op_a} + {1'b0, b_eff}
               + {{WIDTH{1'b0}}, carry_q};
   end

   assign cmd_ready = !reset && (state_q == IDLE);
   assign op_ready  = !reset && (state_q == RUN)
                    && (!res_valid || res_ready);
   assign cmd_hs    = cmd_valid && cmd_ready;
   assign op_hs     = op_valid && op_ready;
   assign busy      = (state_q == RUN) || res_valid;

   // next-state, carry chain and output register load
   always_comb begin
      state_d     = state_q;
      carry_d     = carry_q;
      sub_d       = sub_q;
      count_d     = count_q;
      res_valid_d = res_valid && !res_ready;
      res_sum_d   = res_sum;
      res_last_d  = res_last;
      res_carry_d = res_carry;
      unique case (state_q)
         IDLE: begin
            if (cmd_hs) begin
               sub_d   = cmd_sub;
               carry_d = cmd_sub;
               count_d = eff_words;
               state_d = RUN;
            end
         end
         RUN: begin
            if (op_hs) begin
               res_sum_d   = add_full[WIDTH-1:0];
               res_carry_d = add_full[WIDTH];
               res_last_d  = (count_q == CW'(1));
               res_valid_d = 1'b1;
               carry_d     = add_full[WIDTH];
               count_d     = count_q - CW'(1);
               if (count_q == CW'(1))
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and output registers, synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         carry_q   <= 1'b0;
         sub_q     <= 1'b0;
         count_q   <= '0;
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_last  <= 1'b0;
         res_carry <= 1'b0;
      end else begin
         state_q   <= state_d;
         carry_q   <= carry_d;
         sub_q     <= sub_d;
         count_q   <= count_d;
         res_valid <= res_valid_d;
         res_sum   <= res_sum_d;
         res_last  <= res_last_d;
         res_carry <= res_carry_d;
      end
   end

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq.
// Scoreboard queue fed by the operand driver, drained by a monitor.
module tb_mp_add_seq;

   localparam int W  = 16;
   localparam int MW = 8;
   localparam int CW = $clog2(MW + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [CW-1:0] cmd_words;
   logic          cmd_sub;
   logic          op_valid;
   logic          op_ready;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          res_valid;
   logic          res_ready;
   logic [W-1:0]  res_sum;
   logic          res_last;
   logic          res_carry;
   logic          busy;

   mp_add_seq #(.WIDTH(W), .MAX_WORDS(MW)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_words (cmd_words),
      .cmd_sub   (cmd_sub),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_last  (res_last),
      .res_carry (res_carry),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         carry;
      logic         last;
   } beat_t;

   beat_t exp_q[$];
   beat_t obs_q[$];
   beat_t mon_o;
   beat_t mon_e;
   int    checks   = 0;
   int    failures = 0;
   logic  mdl_sub;
   logic  mdl_carry;
   int    mdl_count;
   int    n_ophs   = 0;

   // monitor: a result handshake happens at the next rising edge
   always @(negedge clk) begin
      if (!reset && res_valid && res_ready) begin
         mon_o = '{sum: res_sum, carry: res_carry, last: res_last};
         obs_q.push_back(mon_o);
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_extra got sum=%h carry=%b last=%b",
                     res_sum, res_carry, res_last);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_o !== mon_e) begin
               failures++;
               $display("FAIL scoreboard got %h/%b/%b want %h/%b/%b",
                        mon_o.sum, mon_o.carry, mon_o.last,
                        mon_e.sum, mon_e.carry, mon_e.last);
            end
         end
      end
   end

   task automatic send_cmd(input int words, input logic sub);
      bit ok = 0;
      int eff;
      eff = (words == 0) ? 1 : ((words > MW) ? MW : words);
      cmd_valid = 1'b1;
      cmd_words = CW'(words);
      cmd_sub   = sub;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL cmd_timeout got cmd_ready=0 want 1");
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      mdl_sub   = sub;
      mdl_carry = sub;
      mdl_count = eff;
   endtask

   task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b);
      bit ok = 0;
      logic [W:0] full;
      op_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (op_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL op_timeout got op_ready=0 want 1");
      end else begin
         full = {1'b0, a} + {1'b0, (mdl_sub ? ~b : b)}
              + {{W{1'b0}}, mdl_carry};
         exp_q.push_back('{sum: full[W-1:0], carry: full[W],
                           last: (mdl_count == 1)});
         mdl_carry = full[W];
         mdl_count--;
         n_ophs++;
      end
      @(posedge clk);
      #1;
      op_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !res_valid) begin
            ok = 1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({cmd_ready, op_ready, res_valid, res_last, res_carry, busy}
          !== 6'b0) begin
         failures++;
         $display("FAIL reset_flags got %b want 000000",
                  {cmd_ready, op_ready, res_valid, res_last, res_carry, busy});
      end
      checks++;
      if (res_sum !== 16'h0000) begin
         failures++;
         $display("FAIL reset_sum got %h want 0000", res_sum);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({cmd_ready, op_ready} !== 2'b10) begin
         failures++;
         $display("FAIL idle_ready got %b want 10", {cmd_ready, op_ready});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_add();
      obs_q.delete();
      send_cmd(1, 1'b0);
      send_op(16'hFFFF, 16'h0001);
      @(negedge clk);
      checks++;
      if ({res_valid, res_sum, res_carry, res_last, cmd_ready}
          !== {1'b1, 16'h0000, 1'b1, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL single_add got v=%b s=%h c=%b l=%b cr=%b want 1 0000 1 1 1",
                  res_valid, res_sum, res_carry, res_last, cmd_ready);
      end
      drain();
      op_valid = 1'b1;
      op_a     = 16'h5555;
      op_b     = 16'h1111;
      repeat (3) @(negedge clk);
      checks++;
      if ({op_ready, res_valid, obs_q.size() == 1} !== 3'b001) begin
         failures++;
         $display("FAIL idle_op_ignored got ordy=%b rv=%b n=%0d want 0 0 1",
                  op_ready, res_valid, obs_q.size());
      end
      @(posedge clk);
      #1;
      op_valid = 1'b0;
   endtask

   task automatic test_carry_chain();
      logic [W-1:0] xs[3] = '{16'h0000, 16'h0000, 16'h0001};
      logic [2:0]   xc    = 3'b011;
      obs_q.delete();
      send_cmd(3, 1'b0);
      send_op(16'hFFFF, 16'h0001);
      send_op(16'hFFFF, 16'h0000);
      send_op(16'h0000, 16'h0000);
      drain();
      checks++;
      if (obs_q.size() != 3) begin
         failures++;
         $display("FAIL chain_count got %0d want 3", obs_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({obs_q[i].sum, obs_q[i].carry, obs_q[i].last}
                !== {xs[i], xc[i], (i == 2)}) begin
               failures++;
               $display("FAIL chain_beat%0d got %h/%b/%b want %h/%b/%b", i,
                        obs_q[i].sum, obs_q[i].carry, obs_q[i].last,
                        xs[i], xc[i], (i == 2));
            end
         end
      end
   endtask

   task automatic test_subtract();
      obs_q.delete();
      send_cmd(2, 1'b1);
      send_op(16'h0000, 16'h0001);
      send_op(16'h0001, 16'h0000);
      send_cmd(1, 1'b1);
      send_op(16'h0000, 16'h0001);
      drain();
      checks++;
      if (obs_q.size() != 3) begin
         failures++;
         $display("FAIL sub_count got %0d want 3", obs_q.size());
      end else begin
         checks++;
         if ({obs_q[0].sum, obs_q[1].sum, obs_q[1].carry, obs_q[1].last}
             !== {16'hFFFF, 16'h0000, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL sub_two got %h %h c=%b want ffff 0000 c=1",
                     obs_q[0].sum, obs_q[1].sum, obs_q[1].carry);
         end
         checks++;
         if ({obs_q[2].sum, obs_q[2].carry} !== {16'hFFFF, 1'b0}) begin
            failures++;
            $display("FAIL sub_borrow got %h c=%b want ffff c=0",
                     obs_q[2].sum, obs_q[2].carry);
         end
      end
   endtask

   task automatic test_backpressure();
      int base;
      logic [W-1:0] held;
      obs_q.delete();
      base = n_ophs;
      send_cmd(4, 1'b0);
      fork
         begin
            send_op(16'hFFFF, 16'h0001);
            send_op(16'hFFFF, 16'h0000);
            send_op(16'h1234, 16'h0001);
            send_op(16'h8000, 16'h8000);
         end
         begin
            for (int i = 0; i < 50 && n_ophs < base + 2; i++)
               @(negedge clk);
            @(posedge clk);
            #1;
            res_ready = 1'b0;
            @(negedge clk);
            held = res_sum;
            for (int i = 0; i < 3; i++) begin
               if (i > 0) @(negedge clk);
               checks++;
               if ({op_ready, res_valid, res_sum} !== {1'b0, 1'b1, held}) begin
                  failures++;
                  $display("FAIL stall_cyc%0d got ordy=%b rv=%b s=%h want 0 1 %h",
                           i, op_ready, res_valid, res_sum, held);
               end
            end
            @(posedge clk);
            #1;
            res_ready = 1'b1;
         end
      join
      drain();
      checks++;
      if (obs_q.size() != 4) begin
         failures++;
         $display("FAIL bp_count got %0d want 4", obs_q.size());
      end else begin
         checks++;
         if ({obs_q[3].sum, obs_q[3].carry, obs_q[3].last}
             !== {16'h0000, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL bp_final got %h/%b/%b want 0000/1/1",
                     obs_q[3].sum, obs_q[3].carry, obs_q[3].last);
         end
      end
   endtask

   task automatic test_clamp();
      int nlast;
      obs_q.delete();
      send_cmd(0, 1'b0);
      send_op(16'h00FF, 16'h0F00);
      drain();
      checks++;
      if (obs_q.size() != 1 || obs_q[0].last !== 1'b1) begin
         failures++;
         $display("FAIL clamp_zero got n=%0d want 1 last", obs_q.size());
      end
      obs_q.delete();
      send_cmd(15, 1'b0);
      for (int i = 0; i < MW; i++)
         send_op(W'($urandom), W'($urandom));
      @(negedge clk);
      checks++;
      if ({cmd_ready, op_ready} !== 2'b10) begin
         failures++;
         $display("FAIL clamp_max_idle got %b want 10", {cmd_ready, op_ready});
      end
      drain();
      nlast = 0;
      foreach (obs_q[i]) if (obs_q[i].last) nlast++;
      checks++;
      if (obs_q.size() != MW || nlast != 1 || !obs_q[MW-1].last) begin
         failures++;
         $display("FAIL clamp_max got n=%0d lasts=%0d want %0d 1",
                  obs_q.size(), nlast, MW);
      end
   endtask

   task automatic test_back_to_back();
      time t0;
      send_cmd(MW, 1'b1);
      t0 = $time;
      for (int i = 0; i < MW; i++)
         send_op(W'($urandom), W'($urandom));
      checks++;
      if ($time - t0 != MW * 10) begin
         failures++;
         $display("FAIL throughput got %0t want %0d", $time - t0, MW * 10);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      obs_q.delete();
      send_cmd(4, 1'b0);
      res_ready = 1'b0;
      send_op(16'hAAAA, 16'h5555);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      res_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({cmd_ready, res_valid, busy} !== 3'b100) begin
         failures++;
         $display("FAIL reset_mid got cr=%b rv=%b busy=%b want 1 0 0",
                  cmd_ready, res_valid, busy);
      end
      @(posedge clk);
      #1;
      send_cmd(1, 1'b0);
      send_op(16'h1234, 16'h0001);
      drain();
      checks++;
      if (obs_q.size() != 1 || {obs_q[0].sum, obs_q[0].carry}
          !== {16'h1235, 1'b0}) begin
         failures++;
         $display("FAIL after_reset got n=%0d want one beat 1235/0",
                  obs_q.size());
      end
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_words = '0;
      cmd_sub   = 1'b0;
      op_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      res_ready = 1'b1;
      mdl_sub   = 1'b0;
      mdl_carry = 1'b0;
      mdl_count = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_single_add();
      test_carry_chain();
      test_subtract();
      test_backpressure();
      test_clamp();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
